motion_centroid_tracker: RTL and testbench

//  Consumes the eroded binary-difference pixel stream produced by the 3x3 erosion/scan stage and

---
 rtl/motion_centroid_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_motion_centroid_tracker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_centroid_tracker.sv
// Per-frame motion centroid: accumulates hit coordinates, divides the sums by the hit count
// one bit per cycle, then low-pass filters the mean position for the VGA overlay marker.
module motion_centroid_tracker #(
  parameter int X_WIDTH   = 9,
  parameter int Y_WIDTH   = 8,
  parameter int SUM_WIDTH = 24,
  parameter int CNT_WIDTH = 17,
  parameter int MIN_COUNT = 300
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [X_WIDTH-1:0]   pix_x,
  input  logic [Y_WIDTH-1:0]   pix_y,
  input  logic                 pix_hit,
  input  logic                 frame_end,
  output logic                 busy,
  output logic [X_WIDTH-1:0]   centroid_x,
  output logic [Y_WIDTH-1:0]   centroid_y,
  output logic                 centroid_valid,
  output logic                 motion_detected,
  output logic                 update_pulse,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 overrun
);

  localparam int BW = $clog2(SUM_WIDTH);

  typedef enum logic [2:0] {
    ACCUM  = 3'd0,
    CHECK  = 3'd1,
    DIV_X  = 3'd2,
    DIV_Y  = 3'd3,
    SMOOTH = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic [SUM_WIDTH-1:0] acc_sx_q, acc_sx_d;
  logic [SUM_WIDTH-1:0] acc_sy_q, acc_sy_d;
  logic [CNT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
  logic [SUM_WIDTH-1:0] lat_sx_q, lat_sx_d;
  logic [SUM_WIDTH-1:0] lat_sy_q, lat_sy_d;
  logic [SUM_WIDTH-1:0] dvd_q, dvd_d;
  logic [SUM_WIDTH-1:0] rem_q, rem_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [X_WIDTH-1:0]   mean_x_q, mean_x_d;
  logic [X_WIDTH-1:0]   cx_q, cx_d;
  logic [Y_WIDTH-1:0]   cy_q, cy_d;
  logic                 valid_q, valid_d;
  logic                 md_q, md_d;
  logic                 up_q, up_d;
  logic [CNT_WIDTH-1:0] fc_q, fc_d;
  logic                 ov_q, ov_d;

  logic                 hit;
  logic [CNT_WIDTH-1:0] cur_cnt;
  logic [SUM_WIDTH-1:0] cur_sx;
  logic [SUM_WIDTH-1:0] cur_sy;
  logic [SUM_WIDTH:0]   rem_sh;
  logic [SUM_WIDTH:0]   divisor;
  logic                 q_bit;
  logic [SUM_WIDTH-1:0] dvd_step;
  logic [SUM_WIDTH-1:0] rem_step;
  logic [X_WIDTH-1:0]   smooth_x;
  logic [Y_WIDTH-1:0]   smooth_y;

  always_comb begin
    hit     = pix_valid && pix_hit;
    cur_cnt = acc_cnt_q + {{(CNT_WIDTH-1){1'b0}}, hit};
    cur_sx  = acc_sx_q + (hit ? {{(SUM_WIDTH-X_WIDTH){1'b0}}, pix_x} : '0);
    cur_sy  = acc_sy_q + (hit ? {{(SUM_WIDTH-Y_WIDTH){1'b0}}, pix_y} : '0);

    // Restoring division step: shift the next dividend bit into the remainder and
    // subtract when possible; the dividend register fills with quotient bits from the right.
    divisor  = {{(SUM_WIDTH+1-CNT_WIDTH){1'b0}}, lat_cnt_q};
    rem_sh   = {rem_q, dvd_q[SUM_WIDTH-1]};
    q_bit    = (rem_sh >= divisor);
    rem_step = q_bit ? SUM_WIDTH'(rem_sh - divisor) : SUM_WIDTH'(rem_sh);
    dvd_step = {dvd_q[SUM_WIDTH-2:0], q_bit};

    // 3/4 old + 1/4 new, two guard bits so the sum cannot wrap before the shift
    smooth_x = X_WIDTH'(({2'b00, cx_q} + {1'b0, cx_q, 1'b0} + {2'b00, mean_x_q}) >> 2);
    smooth_y = Y_WIDTH'(({2'b00, cy_q} + {1'b0, cy_q, 1'b0} + {2'b00, dvd_q[Y_WIDTH-1:0]}) >> 2);
  end

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = cur_cnt;
    acc_sx_d  = cur_sx;
    acc_sy_d  = cur_sy;
    lat_cnt_d = lat_cnt_q;
    lat_sx_d  = lat_sx_q;
    lat_sy_d  = lat_sy_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    bit_d     = bit_q;
    mean_x_d  = mean_x_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    valid_d   = valid_q;
    md_d      = md_q;
    up_d      = 1'b0;
    fc_d      = fc_q;
    ov_d      = ov_q;

    if (frame_end) begin
      acc_cnt_d = '0;
      acc_sx_d  = '0;
      acc_sy_d  = '0;
      if (state_q == ACCUM) begin
        lat_cnt_d = cur_cnt;
        lat_sx_d  = cur_sx;
        lat_sy_d  = cur_sy;
        fc_d      = cur_cnt;
        state_d   = CHECK;
      end else begin
        ov_d = 1'b1;
      end
    end

    case (state_q)
      ACCUM: ;
      CHECK: begin
        if (lat_cnt_q < CNT_WIDTH'(MIN_COUNT)) begin
          md_d    = 1'b0;
          up_d    = 1'b1;
          state_d = ACCUM;
        end else begin
          dvd_d   = lat_sx_q;
          rem_d   = '0;
          bit_d   = BW'(SUM_WIDTH-1);
          state_d = DIV_X;
        end
      end
      DIV_X, DIV_Y: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        bit_d = bit_q - 1'b1;
        if (bit_q == '0) begin
          if (state_q == DIV_X) begin
            mean_x_d = dvd_step[X_WIDTH-1:0];
            dvd_d    = lat_sy_q;
            rem_d    = '0;
            bit_d    = BW'(SUM_WIDTH-1);
            state_d  = DIV_Y;
          end else begin
            state_d = SMOOTH;
          end
        end
      end
      SMOOTH: begin
        // The Y quotient is still sitting in the dividend register here
        cx_d    = valid_q ? smooth_x : mean_x_q;
        cy_d    = valid_q ? smooth_y : dvd_q[Y_WIDTH-1:0];
        valid_d = 1'b1;
        md_d    = 1'b1;
        up_d    = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_cnt_q <= '0;
      acc_sx_q  <= '0;
      acc_sy_q  <= '0;
      lat_cnt_q <= '0;
      lat_sx_q  <= '0;
      lat_sy_q  <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      bit_q     <= '0;
      mean_x_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      valid_q   <= 1'b0;
      md_q      <= 1'b0;
      up_q      <= 1'b0;
      fc_q      <= '0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      acc_sx_q  <= acc_sx_d;
      acc_sy_q  <= acc_sy_d;
      lat_cnt_q <= lat_cnt_d;
      lat_sx_q  <= lat_sx_d;
      lat_sy_q  <= lat_sy_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      bit_q     <= bit_d;
      mean_x_q  <= mean_x_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      valid_q   <= valid_d;
      md_q      <= md_d;
      up_q      <= up_d;
      fc_q      <= fc_d;
      ov_q      <= ov_d;
    end
  end

  assign busy            = (state_q != ACCUM);
  assign centroid_x      = cx_q;
  assign centroid_y      = cy_q;
  assign centroid_valid  = valid_q;
  assign motion_detected = md_q;
  assign update_pulse    = up_q;
  assign frame_count     = fc_q;
  assign overrun         = ov_q;

endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Randomized bench for motion_centroid_tracker: a frame-level model (sums, integer mean,
// weighted average) predicts centroid, flags and update latency for every frame.
module tb_motion_centroid_tracker;

  localparam int MIN_COUNT = 300;
  localparam int LONG_LAT  = 50;  // edges from frame_end sample to visible update

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [8:0]  pix_x = '0;
  logic [7:0]  pix_y = '0;
  logic        pix_hit = 1'b0;
  logic        frame_end = 1'b0;
  logic        busy;
  logic [8:0]  centroid_x;
  logic [7:0]  centroid_y;
  logic        centroid_valid;
  logic        motion_detected;
  logic        update_pulse;
  logic [16:0] frame_count;
  logic        overrun;

  motion_centroid_tracker dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_hit         (pix_hit),
    .frame_end       (frame_end),
    .busy            (busy),
    .centroid_x      (centroid_x),
    .centroid_y      (centroid_y),
    .centroid_valid  (centroid_valid),
    .motion_detected (motion_detected),
    .update_pulse    (update_pulse),
    .frame_count     (frame_count),
    .overrun         (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level reference state
  int m_cnt, m_sx, m_sy;
  int snap_cnt, snap_sx, snap_sy;
  int exp_cx, exp_cy, exp_fc;
  bit exp_valid, exp_md, exp_ov;
  bit noise_en;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    exp_cx = 0; exp_cy = 0; exp_fc = 0;
    exp_valid = 0; exp_md = 0; exp_ov = 0;
  endtask

  task automatic drive_pix(input bit v, input int x, input int y, input bit h, input bit fe);
    pix_valid = v;
    pix_x     = x[8:0];
    pix_y     = y[7:0];
    pix_hit   = h;
    frame_end = fe;
    if (v && h) begin
      m_cnt++; m_sx += x; m_sy += y;
    end
    if (fe) begin
      snap_cnt = m_cnt; snap_sx = m_sx; snap_sy = m_sy;
      m_cnt = 0; m_sx = 0; m_sy = 0;
    end
    @(posedge CLOCK_50);
    #1;
    pix_valid = 1'b0;
    pix_hit   = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic rand_pix(input bit fe);
    drive_pix(noise_en && ($urandom % 2 == 0), $urandom_range(0, 319),
              $urandom_range(0, 239), ($urandom % 4 == 0), fe);
  endtask

  task automatic check_outputs(input string tag, input bit chk_fc);
    check_eq({tag, "_cx"}, centroid_x, exp_cx);
    check_eq({tag, "_cy"}, centroid_y, exp_cy);
    check_eq({tag, "_valid"}, centroid_valid, exp_valid);
    check_eq({tag, "_motion"}, motion_detected, exp_md);
    check_eq({tag, "_overrun"}, overrun, exp_ov);
    if (chk_fc) check_eq({tag, "_fcount"}, frame_count, exp_fc);
  endtask

  // Streams one frame with h hits, ends it and updates the model; returns expected latency.
  task automatic gen_frame(input string tag, input int h, input int mode, input int fx,
                           input int fy, output int lat);
    bit done = 0;
    int x, y, mx, my;
    if (h < m_cnt) h = m_cnt;
    while (!done && m_cnt < h) begin
      case (mode)
        0: begin x = $urandom_range(0, 319); y = $urandom_range(0, 239); end
        1: begin x = fx; y = fy; end
        2: begin x = 319; y = 239; end
        default: begin x = fx + $urandom_range(0, 15); y = fy + $urandom_range(0, 15); end
      endcase
      if (noise_en && $urandom % 3 == 0) begin
        drive_pix($urandom % 2 == 0, x, y, 1'b0, 1'b0);
      end else begin
        done = (m_cnt == h - 1) && ($urandom % 2 == 0);
        drive_pix(1'b1, x, y, 1'b1, done);
      end
    end
    if (!done) drive_pix(noise_en && ($urandom % 2 == 0), 7, 7, 1'b0, 1'b1);
    check_eq({tag, "_busy_after_fe"}, busy, 1);
    check_eq({tag, "_fcount_latched"}, frame_count, snap_cnt);
    exp_fc = snap_cnt;
    if (snap_cnt < MIN_COUNT) begin
      exp_md = 0;
      lat = 1;
    end else begin
      mx = snap_sx / snap_cnt;
      my = snap_sy / snap_cnt;
      if (exp_valid) begin
        exp_cx = (3 * exp_cx + mx) / 4;
        exp_cy = (3 * exp_cy + my) / 4;
      end else begin
        exp_cx = mx;
        exp_cy = my;
      end
      exp_valid = 1;
      exp_md = 1;
      lat = LONG_LAT;
    end
  endtask

  // Runs 60 cycles after frame_end, optionally firing a second frame_end at ov_at.
  task automatic await_update(input string tag, input int exp_lat, input int ov_at);
    int lat = -1;
    int pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      rand_pix(k == ov_at);
      if (update_pulse) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          check_eq({tag, "_busy_at_update"}, busy, 0);
        end
      end
    end
    if (ov_at > 0) exp_ov = 1;
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_pulses"}, pulses, 1);
  endtask

  task automatic run_frame(input string tag, input int h, input int mode, input int fx,
                           input int fy, input int ov_at);
    int lat;
    gen_frame(tag, h, mode, fx, fy, lat);
    await_update(tag, lat, ov_at);
    check_outputs(tag, ov_at == 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_update"}, update_pulse, 0);
    check_outputs(tag, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, sel, lat, pulses;
    model_reset();
    noise_en = 0;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Directed frames: identical point clouds give exact, hand-checkable means
    run_frame("dir1", 400, 1, 100, 50, 0);
    check_eq("dir1_cx_const", centroid_x, 100);
    run_frame("dir2", 400, 1, 200, 90, 0);
    check_eq("dir2_cx_const", centroid_x, 125);
    check_eq("dir2_cy_const", centroid_y, 60);
    run_frame("dir3", 299, 1, 10, 10, 0);
    check_eq("dir3_fcount_const", frame_count, 299);
    run_frame("dir4", 300, 2, 0, 0, 0);

    // Random frames with noise, threshold edges, busy-time pixels and one overrun
    noise_en = 1;
    for (int i = 0; i < 12; i++) begin
      sel = $urandom % 5;
      case (sel)
        0: h = 299;
        1: h = 300;
        2: h = $urandom_range(0, 298);
        default: h = $urandom_range(301, 900);
      endcase
      if (i == 6) h = 500;
      run_frame($sformatf("rnd%0d", i), h, $urandom % 4, $urandom_range(0, 300),
                $urandom_range(0, 220), (i == 6) ? 10 : 0);
    end

    // Reset in the middle of DIV_X aborts everything and posts nothing
    gen_frame("rstdiv", 600, 0, 0, 0, lat);
    for (int k = 1; k < 20; k++) rand_pix(1'b0);
    reset = 1'b1;
    drive_pix(1'b0, 0, 0, 1'b0, 1'b0);
    model_reset();
    check_all_zero("rstdiv");
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      rand_pix(1'b0);
      if (update_pulse) pulses++;
    end
    check_eq("rstdiv_no_pulse", pulses, 0);

    // Restart after reset: first valid frame takes the mean with no history
    run_frame("post_rst", 450, 3, 40, 30, 0);
    run_frame("post_rst2", 350, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
